// File: rtl/div_pkg.sv
// Shared types and helpers for the iterative divider.
//   op_e    : operation encoding presented on the op port
//   state_e : controller FSM states
//   AluAdd/AluSub/AluAnd/AluOr : arithmetic_unit Sel encodings
package div_pkg;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    StIdle,
    StPrep,
    StIter,
    StFix,
    StDone
  } state_e;

  localparam logic [1:0] AluAdd = 2'b00;
  localparam logic [1:0] AluSub = 2'b01;
  localparam logic [1:0] AluAnd = 2'b10;
  localparam logic [1:0] AluOr  = 2'b11;

  // DIV and REM treat operands as two's complement.
  function automatic logic is_signed_op(op_e op);
    return (op == DIV) || (op == REM);
  endfunction

  // REM and REMU return the remainder instead of the quotient.
  function automatic logic is_rem_op(op_e op);
    return (op == REM) || (op == REMU);
  endfunction

endpackage

// File: rtl/arithmetic_unit.sv
// Combinational arithmetic/logic unit.
//   Sel : 00 add, 01 subtract (A - B), 10 bitwise and, 11 bitwise or
//   A,B : operands, size bits
//   Y   : result, size bits
//   C   : carry-out; for subtract, 1 means no borrow (A >= B unsigned)
module arithmetic_unit
  import div_pkg::*;
#(
  parameter int unsigned size = 33
) (
  input  logic [1:0]      Sel,
  input  logic [size-1:0] A,
  input  logic [size-1:0] B,
  output logic [size-1:0] Y,
  output logic            C
);

  always_comb begin
    Y = '0;
    C = 1'b0;
    unique case (Sel)
      AluAdd:  {C, Y} = {1'b0, A} + {1'b0, B};
      AluSub:  {C, Y} = {1'b0, A} + {1'b0, ~B} + {{size{1'b0}}, 1'b1};
      AluAnd:  Y = A & B;
      AluOr:   Y = A | B;
      default: Y = '0;
    endcase
  end

endmodule

// File: rtl/iterative_divider_ctrl.sv
// Multi-cycle restoring divider with valid/ready handshakes on both sides.
//   clk       : rising-edge clock
//   reset     : synchronous active-high reset
//   valid_in  : request valid; accepted when ready_out is high
//   ready_out : high only while idle
//   op        : 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   A, B      : dividend, divisor (captured at the handshake)
//   valid_out : result valid (DONE state only)
//   ready_in  : consumer accepts the result
//   result    : quotient or remainder, held stable while valid_out is high
// Latency: valid_out rises size+2 edges after the handshake edge, or one edge
// after it for divide-by-zero and signed overflow.
module iterative_divider_ctrl
  import div_pkg::*;
#(
  parameter int unsigned size = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_in,
  output logic            ready_out,
  input  logic [1:0]      op,
  input  logic [size-1:0] A,
  input  logic [size-1:0] B,
  output logic            valid_out,
  input  logic            ready_in,
  output logic [size-1:0] result
);

  localparam int unsigned CntW = $clog2(size) + 1;
  localparam logic [CntW-1:0] LastStep = CntW'(size - 1);
  localparam logic [size-1:0] MinInt = {1'b1, {(size - 1){1'b0}}};

  state_e state_q, state_d;

  op_e             op_q;
  logic [size-1:0] a_q, b_q;
  logic [size-1:0] dvd_q;     // dividend shifting out, quotient shifting in
  logic [size-1:0] dsr_q;     // divisor magnitude
  logic [size:0]   rem_q;     // partial remainder
  logic [CntW-1:0] cnt_q;
  logic            qsign_q, rsign_q;
  logic [size-1:0] result_q;

  logic            op_signed, op_rem, div_by_zero, overflow;
  logic [size:0]   shifted, diff, rem_d;
  logic            no_borrow;
  logic [size-1:0] quo_fix, rem_fix;
  logic            unused_rem_msb;

  assign op_signed   = is_signed_op(op_q);
  assign op_rem      = is_rem_op(op_q);
  assign div_by_zero = (b_q == '0);
  assign overflow    = op_signed && (a_q == MinInt) && (b_q == '1);

  // The partial remainder never exceeds size bits between steps, so its MSB
  // drops out of the shift.
  assign shifted        = {rem_q[size-1:0], dvd_q[size-1]};
  assign unused_rem_msb = rem_q[size];

  arithmetic_unit #(
    .size(size + 1)
  ) u_sub (
    .Sel(AluSub),
    .A  (shifted),
    .B  ({1'b0, dsr_q}),
    .Y  (diff),
    .C  (no_borrow)
  );

  assign rem_d   = no_borrow ? diff : shifted;
  assign quo_fix = (op_signed && qsign_q) ? -dvd_q : dvd_q;
  assign rem_fix = (op_signed && rsign_q) ? -rem_q[size-1:0] : rem_q[size-1:0];

  // Next-state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    ready_out = 1'b0;
    valid_out = 1'b0;
    unique case (state_q)
      StIdle: begin
        ready_out = 1'b1;
        if (valid_in) state_d = StPrep;
      end
      StPrep: state_d = (div_by_zero || overflow) ? StDone : StIter;
      StIter: if (cnt_q == LastStep) state_d = StFix;
      StFix:  state_d = StDone;
      StDone: begin
        valid_out = 1'b1;
        if (ready_in) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q     <= DIVU;
      a_q      <= '0;
      b_q      <= '0;
      dvd_q    <= '0;
      dsr_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      qsign_q  <= 1'b0;
      rsign_q  <= 1'b0;
      result_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (valid_in) begin
            op_q <= op_e'(op);
            a_q  <= A;
            b_q  <= B;
          end
        end
        StPrep: begin
          dvd_q   <= (op_signed && a_q[size-1]) ? -a_q : a_q;
          dsr_q   <= (op_signed && b_q[size-1]) ? -b_q : b_q;
          qsign_q <= a_q[size-1] ^ b_q[size-1];
          rsign_q <= a_q[size-1];
          rem_q   <= '0;
          cnt_q   <= '0;
          if (div_by_zero) begin
            result_q <= op_rem ? a_q : '1;
          end else if (overflow) begin
            result_q <= op_rem ? '0 : a_q;
          end
        end
        StIter: begin
          rem_q <= rem_d;
          dvd_q <= {dvd_q[size-2:0], no_borrow};
          cnt_q <= cnt_q + 1'b1;
        end
        StFix: result_q <= op_rem ? rem_fix : quo_fix;
        default: ;
      endcase
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_iterative_divider_ctrl.sv
module tb_iterative_divider_ctrl;

  localparam int unsigned Size = 32;
  localparam int unsigned NormCyc = Size + 3;
  localparam int unsigned Bound = 200;

  typedef struct {
    logic [31:0] res;
    logic [31:0] cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        valid_in = 1'b0;
  logic        ready_out;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        valid_out;
  logic        ready_in = 1'b1;
  logic [31:0] result;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail = 0;

  iterative_divider_ctrl #(
    .size(Size)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .valid_in (valid_in),
    .ready_out(ready_out),
    .op       (op),
    .A        (a),
    .B        (b),
    .valid_out(valid_out),
    .ready_in (ready_in),
    .result   (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: behavioural division with the documented special cases.
  function automatic exp_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    logic signed [31:0] sx, sy;
    sx = x;
    sy = y;
    e.cyc = NormCyc;
    if (y == 0) begin
      e.res = o[1] ? x : 32'hFFFF_FFFF;
      e.cyc = 2;
    end else if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
      e.res = o[1] ? 32'h0 : x;
      e.cyc = 2;
    end else if (!o[0]) begin
      e.res = o[1] ? 32'(sx % sy) : 32'(sx / sy);
    end else begin
      e.res = o[1] ? x % y : x / y;
    end
    return e;
  endfunction

  // Drive one request; returns #1 after the handshake edge.
  task automatic send(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                      input logic [31:0] exp_res, input logic [31:0] exp_cyc,
                      input bit push, input bit hold_valid);
    exp_t e;
    int   w;
    w = 0;
    while (!ready_out && w < Bound) begin
      @(posedge clk);
      #1;
      w++;
    end
    if (w >= Bound) check("ready_timeout", {31'b0, ready_out}, 32'd1);
    op       = o;
    a        = x;
    b        = y;
    valid_in = 1'b1;
    if (push) begin
      e.res = exp_res;
      e.cyc = exp_cyc;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    if (!hold_valid) valid_in = 1'b0;
  endtask

  // Wait for the result and compare against the scoreboard head.
  task automatic collect(input string tag);
    exp_t e;
    int   lat;
    lat = 0;
    while (!valid_out && lat < Bound) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (sb.size() == 0) begin
      check({tag, "_sb_underflow"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    check({tag, "_cycle"}, 32'(lat + 1), e.cyc);
    check({tag, "_result"}, result, e.res);
    if (ready_in) begin
      @(posedge clk);
      #1;
      check({tag, "_vout_low"}, {31'b0, valid_out}, 32'd0);
      check({tag, "_rdy_back"}, {31'b0, ready_out}, 32'd1);
    end
  endtask

  initial begin
    logic [31:0] held;
    exp_t        e;

    // Reset with a request already presented: must not be taken.
    valid_in = 1'b1;
    op       = 2'b01;
    a        = 32'd50;
    b        = 32'd5;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'b0, ready_out}, 32'd1);
    check("rst_valid", {31'b0, valid_out}, 32'd0);
    check("rst_result", result, 32'd0);
    reset    = 1'b0;
    valid_in = 1'b0;
    @(posedge clk);
    #1;
    check("rst_no_accept", {31'b0, ready_out}, 32'd1);

    // Directed vectors.
    send(2'b01, 32'd100, 32'd7, 32'd14, NormCyc, 1, 0);                   collect("divu_100_7");
    send(2'b11, 32'd100, 32'd7, 32'd2, NormCyc, 1, 0);                    collect("remu_100_7");
    send(2'b00, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, NormCyc, 1, 0);      collect("div_m100_7");
    send(2'b10, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, NormCyc, 1, 0);      collect("rem_m100_7");
    send(2'b00, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, NormCyc, 1, 0);    collect("div_100_m7");
    send(2'b10, 32'd100, 32'hFFFF_FFF9, 32'd2, NormCyc, 1, 0);            collect("rem_100_m7");
    send(2'b00, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, NormCyc, 1, 0);     collect("div_m100_m7");
    send(2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd2, 1, 0);                collect("divu_by0");
    send(2'b11, 32'd5, 32'd0, 32'd5, 32'd2, 1, 0);                        collect("remu_by0");
    send(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd2, 1, 0); collect("div_ovf");
    send(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd2, 1, 0);        collect("rem_ovf");
    send(2'b01, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, NormCyc, 1, 0);      collect("divu_wide");
    send(2'b11, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, NormCyc, 1, 0); collect("remu_wide");

    // Random vectors against the behavioural model.
    for (int i = 0; i < 8; i++) begin
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i % 2 == 0) ? 32'($urandom_range(1, 50)) : $urandom;
      e  = model(ro, ra, rb);
      send(ro, ra, rb, e.res, e.cyc, 1, 0);
      collect("rand");
    end

    // Back-pressure: hold ready_in low in DONE with valid_in still asserted.
    ready_in = 1'b0;
    send(2'b01, 32'd100, 32'd7, 32'd14, NormCyc, 1, 1);
    collect("hold");
    held = result;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("hold_valid", {31'b0, valid_out}, 32'd1);
      check("hold_result", result, held);
      check("hold_no_accept", {31'b0, ready_out}, 32'd0);
    end
    ready_in = 1'b1;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    check("release_ready", {31'b0, ready_out}, 32'd1);
    check("release_valid", {31'b0, valid_out}, 32'd0);
    @(posedge clk);
    #1;
    check("release_idle", {31'b0, ready_out}, 32'd1);

    // Reset in the middle of the iteration: no output, back to idle.
    send(2'b01, 32'd1000, 32'd3, 32'd0, 32'd0, 0, 0);
    repeat (11) @(posedge clk);
    #1;
    check("mid_busy", {31'b0, ready_out}, 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("abort_ready", {31'b0, ready_out}, 32'd1);
    check("abort_valid", {31'b0, valid_out}, 32'd0);
    check("abort_result", result, 32'd0);
    repeat (40) begin
      @(posedge clk);
      #1;
      if (valid_out) check("abort_spurious", {31'b0, valid_out}, 32'd0);
    end
    send(2'b01, 32'd9, 32'd3, 32'd3, NormCyc, 1, 0);
    collect("after_abort");

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/iterative_divider_ctrl.md
ITERATIVE_DIVIDER_CTRL -- requirements
Module: iterative_divider_ctrl

Interface
REQ-001 Parameter: size, default 32, operand/result width in bits.
REQ-002 clk  input  1  rising-edge clock; all state updates on this edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 valid_in  input  1  request valid.
REQ-005 ready_out  output  1  block can accept a request.
REQ-006 op  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-007 A  input  size  dividend.
REQ-008 B  input  size  divisor.
REQ-009 valid_out  output  1  result valid.
REQ-010 ready_in  input  1  consumer accepts result.
REQ-011 result  output  size  quotient (DIV/DIVU) or remainder (REM/REMU).

Function
REQ-012 States SHALL be IDLE, PREP, ITER, FIX, DONE; ready_out SHALL be 1 only in IDLE.
REQ-013 Handshake SHALL occur when valid_in & ready_out at a clock edge (cycle 0); op, A, B SHALL be captured then and ignored afterwards.
REQ-014 IDLE -> PREP on handshake; otherwise stay IDLE.
REQ-015 PREP (cycle 1): signed ops take |A|, |B| in two's complement; record quotient sign = A[size-1]^B[size-1] and remainder sign = A[size-1]; unsigned ops take operands unchanged; iteration counter cleared.
REQ-016 PREP -> DONE directly when B == 0: result = all-ones for DIV/DIVU, = captured A for REM/REMU.
REQ-017 PREP -> DONE directly for signed overflow (A = 1 followed by zeros, B = all-ones): result = A for DIV, 0 for REM.
REQ-018 Otherwise PREP -> ITER; ITER SHALL run exactly size cycles (cycles 2..size+1), one restoring step per cycle, counter incremented each cycle.
REQ-019 Restoring step: partial remainder (size+1 bits) shifted left one, LSB = next dividend MSB; subtract zero-extended divisor via the arithmetic unit in subtract mode (Sel = 01); if carry-out C = 1 (no borrow) keep difference and shift quotient bit 1, else keep shifted value and shift 0.
REQ-020 ITER -> FIX after the size-th step; FIX (cycle size+2) SHALL negate quotient if quotient sign set (signed op) and negate remainder if remainder sign set (signed op), and select result by op.
REQ-021 FIX -> DONE; valid_out SHALL first be 1 at cycle size+3 (35 for size 32) normal path, cycle 2 for REQ-016/017 paths.
REQ-022 In DONE valid_out = 1 and result SHALL be held stable until ready_in = 1; DONE -> IDLE on that edge; valid_out = 0 and ready_out = 1 the following cycle (no same-cycle re-accept).
REQ-023 valid_out SHALL be 0 in all states other than DONE; result value outside DONE is don't-care but SHALL not glitch within DONE.
REQ-024 Remainder SHALL satisfy A = quotient*B + remainder with |remainder| < |B| for all non-special cases.

Reset
REQ-025 On reset = 1 at an edge, state SHALL be IDLE, valid_out 0, ready_out 1, result 0, counter 0, from any state including mid-ITER and DONE.
REQ-026 A request presented in the reset cycle SHALL NOT be accepted; in-flight operation SHALL be discarded without output.

Structure
REQ-027 Package div_pkg SHALL hold the op typedef enum (DIV, DIVU, REM, REMU) and the state typedef enum.
REQ-028 One sub-module instance: arithmetic_unit with size parameter = size+1, Sel tied to 01, used for every restoring subtract; no other adder/subtractor for the iteration step.
REQ-029 Negations in PREP/FIX SHALL be two's complement on size bits; counter width SHALL be $clog2(size)+1.

Verification
REQ-030 DIVU A=100, B=7, ready_in=1 -> valid_out at cycle 35, result 14; REMU same operands -> 2.
REQ-031 DIV A=-100, B=7 -> result -14 (0xFFFFFFF2); REM A=-100, B=7 -> -2 (0xFFFFFFFE); DIV A=100, B=-7 -> -14.
REQ-032 DIVU A=5, B=0 -> valid_out at cycle 2, result 0xFFFFFFFF; REMU A=5, B=0 -> 5; DIV A=0x80000000, B=0xFFFFFFFF -> 0x80000000 at cycle 2, REM -> 0.
REQ-033 DIVU A=0xFFFFFFFF, B=0x80000001 -> 1, REMU -> 0x7FFFFFFE (exercises size+1 remainder width).
REQ-034 Hold ready_in=0 for 10 cycles in DONE -> valid_out and result stable; assert ready_in -> ready_out=1 next cycle; valid_in held high throughout never re-accepted early.
REQ-035 Assert reset at cycle 10 of ITER -> IDLE next cycle, valid_out 0, result 0; new request DIVU 9/3 afterwards -> 3 at normal latency.
